// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : 5-stage pipeline sequencing controller. Resolves load-use stalls,
//            taken-branch flushes and multi-cycle data-memory waits, and keeps
//            saturating stall/flush counters for performance debug.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        ifid_uses_rt_i,
    input  logic        branch_taken_i,
    input  logic        exmem_memreq_i,
    input  logic        dmem_ack_i,
    output logic        pc_we_o,
    output logic        ifid_we_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        pipe_we_o,
    output logic        memwb_bubble_o,
    output logic        dmem_req_o,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] c_STALL_MAX = 32'hFFFF_FFFF;
    localparam logic [15:0] c_FLUSH_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_lu;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_ifid_flush;
    logic w_idex_bubble;
    logic w_pipe_we;
    logic w_memwb_bubble;
    logic w_dmem_req;

    // Load in EX writes a register the instruction in ID is about to read.
    assign w_lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) ||
                   (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

    // Next-state and per-cycle pipeline control; memory freeze dominates,
    // then load-use stall, then branch flush.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_pipe_we      = 1'b1;
        w_memwb_bubble = 1'b0;
        w_dmem_req     = 1'b0;

        if (!rst_i) begin
            w_state_nxt    = S_RUN;
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_pipe_we      = 1'b0;
            w_idex_bubble  = 1'b1;
            w_memwb_bubble = 1'b1;
        end else if ((r_state == S_MEM_WAIT || exmem_memreq_i) && !dmem_ack_i) begin
            // Memory not done: freeze everything upstream of MEM/WB and feed
            // MEM/WB a bubble each waiting cycle.
            w_dmem_req     = 1'b1;
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_pipe_we      = 1'b0;
            w_memwb_bubble = 1'b1;
            w_state_nxt    = S_MEM_WAIT;
        end else begin
            // Request (if any) completes this cycle; keep it asserted so the
            // request never drops before its ack.
            w_dmem_req  = (r_state == S_MEM_WAIT) || exmem_memreq_i;
            w_state_nxt = S_RUN;
            if (w_lu) begin
                // Branch in the same cycle is dropped; it re-resolves once
                // the load has moved on.
                w_pc_we       = 1'b0;
                w_ifid_we     = 1'b0;
                w_idex_bubble = 1'b1;
            end else if (branch_taken_i) begin
                w_ifid_flush = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != c_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_ifid_flush && (r_flush_cnt != c_FLUSH_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign pc_we_o        = w_pc_we;
    assign ifid_we_o      = w_ifid_we;
    assign ifid_flush_o   = w_ifid_flush;
    assign idex_bubble_o  = w_idex_bubble;
    assign pipe_we_o      = w_pipe_we;
    assign memwb_bubble_o = w_memwb_bubble;
    assign dmem_req_o     = w_dmem_req;
    assign stall_cnt_o    = r_stall_cnt;
    assign flush_cnt_o    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rt_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        ifid_uses_rt_i;
    logic        branch_taken_i;
    logic        exmem_memreq_i;
    logic        dmem_ack_i;
    logic        pc_we_o;
    logic        ifid_we_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic        pipe_we_o;
    logic        memwb_bubble_o;
    logic        dmem_req_o;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    // Control vector order: pc_we, ifid_we, ifid_flush, idex_bubble,
    // pipe_we, memwb_bubble, dmem_req.
    localparam logic [6:0] c_RST    = 7'b0001010;
    localparam logic [6:0] c_RUN    = 7'b1100100;
    localparam logic [6:0] c_LU     = 7'b0001100;
    localparam logic [6:0] c_BR     = 7'b1110100;
    localparam logic [6:0] c_FREEZE = 7'b0000011;
    localparam logic [6:0] c_ACK    = 7'b1100101;

    wire logic [6:0] w_ctrl = {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
                               pipe_we_o, memwb_bubble_o, dmem_req_o};

    hazard_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .branch_taken_i (branch_taken_i),
        .exmem_memreq_i (exmem_memreq_i),
        .dmem_ack_i     (dmem_ack_i),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_we_o      (pipe_we_o),
        .memwb_bubble_o (memwb_bubble_o),
        .dmem_req_o     (dmem_req_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs at the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rst, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic mq, input logic ack);
        @(negedge clk_i);
        rst_i = rst; idex_memread_i = mr; idex_rt_i = ert; ifid_rs_i = rs;
        ifid_rt_i = rt; ifid_uses_rt_i = urt; branch_taken_i = br;
        exmem_memreq_i = mq; dmem_ack_i = ack;
        #1;
    endtask

    task automatic quiet();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b0; idex_memread_i = 1'b0; idex_rt_i = '0; ifid_rs_i = '0;
        ifid_rt_i = '0; ifid_uses_rt_i = 1'b0; branch_taken_i = 1'b0;
        exmem_memreq_i = 1'b0; dmem_ack_i = 1'b0;

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("reset_ctrl", 32'(w_ctrl), 32'(c_RST));
        end
        quiet();
        chk("release_ctrl", 32'(w_ctrl), 32'(c_RUN));
        chk("reset_stall_cnt", stall_cnt_o, 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);

        // Load-use on rs.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rs_ctrl", 32'(w_ctrl), 32'(c_LU));
        quiet();
        chk("lu_clear_ctrl", 32'(w_ctrl), 32'(c_RUN));
        chk("lu_stall_cnt", stall_cnt_o, 32'd1);

        // Destination r0 never hazards.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_r0_ctrl", 32'(w_ctrl), 32'(c_RUN));

        // rt match only matters when ID uses rt.
        drive(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_ctrl", 32'(w_ctrl), 32'(c_LU));
        drive(1'b1, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_unused_ctrl", 32'(w_ctrl), 32'(c_RUN));
        chk("lu_rt_stall_cnt", stall_cnt_o, 32'd2);

        // Branch colliding with load-use: stall wins, then branch flushes.
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_lu_ctrl", 32'(w_ctrl), 32'(c_LU));
        drive(1'b1, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("br_ctrl", 32'(w_ctrl), 32'(c_BR));
        chk("br_stall_cnt", stall_cnt_o, 32'd3);
        quiet();
        chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);

        // Memory wait: ack arrives 3 cycles after the request.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("mem_wait_ctrl", 32'(w_ctrl), 32'(c_FREEZE));
        end
        // Ack cycle; the memreq input is deliberately low to show MEM_WAIT holds the request.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mem_ack_ctrl", 32'(w_ctrl), 32'(c_ACK));
        quiet();
        chk("mem_back_run_ctrl", 32'(w_ctrl), 32'(c_RUN));
        chk("mem_stall_cnt", stall_cnt_o, 32'd6);

        // Same-cycle ack: no freeze, no stall.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mem_fast_ctrl", 32'(w_ctrl), 32'(c_ACK));
        quiet();
        chk("mem_fast_stall_cnt", stall_cnt_o, 32'd6);

        // Ack cycle that also sees a load-use: freeze released, stall applies.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mem_ack_lu_ctrl", 32'(w_ctrl), 32'(c_LU) | 32'h1);

        // Reset while waiting on memory.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_wait_enter_ctrl", 32'(w_ctrl), 32'(c_FREEZE));
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_wait_ctrl", 32'(w_ctrl), 32'(c_RST));
        quiet();
        chk("rst_wait_release_ctrl", 32'(w_ctrl), 32'(c_RUN));
        chk("rst_wait_stall_cnt", stall_cnt_o, 32'd0);

        // Stall counter saturation from a preloaded near-max value.
        @(negedge clk_i);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        idex_memread_i = 1'b1; idex_rt_i = 5'd9; ifid_rs_i = 5'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            chk("sat_stall_cnt", stall_cnt_o, 32'hFFFF_FFFF);
        end
        quiet();
        chk("sat_hold_stall_cnt", stall_cnt_o, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage CPU. Decides each cycle whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers capture, hold, or are loaded with a bubble. It covers three cases: load-use hazards, taken-branch flush, and a multi-cycle data-memory request/acknowledge handshake. It also keeps saturating stall and flush counters for performance debug.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- idex_memread_i  in  1  instruction in EX is a load (ID/EX M field, read bit).
- idex_rt_i  in  5  destination register of the instruction in EX.
- ifid_rs_i  in  5  rs field of the instruction in ID.
- ifid_rt_i  in  5  rt field of the instruction in ID.
- ifid_uses_rt_i  in  1  instruction in ID reads rt as a source.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- exmem_memreq_i  in  1  instruction in MEM is a load or store.
- dmem_ack_i  in  1  data memory has completed the current request.
- pc_we_o  out  1  PC write enable.
- ifid_we_o  out  1  IF/ID write enable.
- ifid_flush_o  out  1  load NOP into IF/ID.
- idex_bubble_o  out  1  zero the WB/M/EX control fields entering ID/EX.
- pipe_we_o  out  1  write enable for ID/EX and EX/MEM.
- memwb_bubble_o  out  1  zero the WB control entering MEM/WB.
- dmem_req_o  out  1  data-memory request.
- stall_cnt_o  out  32  number of cycles with pc_we_o=0.
- flush_cnt_o  out  16  number of cycles with ifid_flush_o=1.

## Operation
- FSM states: RUN and MEM_WAIT. Reset state is RUN.
- Reset (rst_i=0 at an edge): state←RUN, stall_cnt_o←0, flush_cnt_o←0.
- While rst_i=0, outputs are forced: all write enables 0, ifid_flush_o=0, idex_bubble_o=1, memwb_bubble_o=1, dmem_req_o=0.
- Load-use hazard, combinational: lu = idex_memread_i & (idex_rt_i≠0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & idex_rt_i==ifid_rt_i)).
- Behaviour in RUN, evaluated in priority order:
  1. Memory: if exmem_memreq_i=1, then dmem_req_o=1. If dmem_ack_i=0 the same cycle, this is a full freeze: pc_we_o, ifid_we_o and pipe_we_o are 0, memwb_bubble_o=1, ifid_flush_o=0, idex_bubble_o=0, and next state is MEM_WAIT. If dmem_ack_i=1 there is no stall and evaluation continues with rules 2–4.
  2. lu=1: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1, pipe_we_o=1, ifid_flush_o=0. A simultaneous branch_taken_i is ignored; the branch re-resolves the next cycle.
  3. branch_taken_i=1: ifid_flush_o=1, all write enables 1.
  4. Otherwise: all write enables 1, both bubbles 0, flush 0.
- Behaviour in MEM_WAIT:
  - dmem_req_o=1 is held continuously.
  - Full freeze as in rule 1, until dmem_ack_i=1.
  - On the ack cycle: freeze is released; rules 2–4 apply using current inputs; memwb_bubble_o=0; next state RUN.
- Any pipeline write enable must be 1 whenever the corresponding bubble or flush output is 1.
- Counters:
  - stall_cnt_o +1 every non-reset cycle with pc_we_o=0; saturates at 0xFFFF_FFFF.
  - flush_cnt_o +1 on each ifid_flush_o=1 cycle; saturates at 0xFFFF.
- Reset asserted during MEM_WAIT: return to RUN and drop dmem_req_o the following cycle. The memory side must tolerate an abandoned request.

## Timing
- All hazard outputs are combinational from state and inputs. The PC and the pipeline registers sample them at the same clock edge.
- Load-use costs exactly 1 stall cycle: on the next cycle idex_memread_i=0 because of the bubble, so lu clears.
- Memory request acked in the same cycle: 0 stall cycles.
- Memory ack arriving N cycles after the request: N stall cycles, with MEM/WB receiving N bubbles.
- Taken branch costs 1 flushed slot and 0 stall cycles.
- dmem_req_o never drops between request and ack, except under reset.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with random inputs -> all write enables 0, both bubbles 1, dmem_req_o=0, counters 0. First cycle after release with quiet inputs -> all write enables 1.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 -> one cycle with pc_we_o=0, ifid_we_o=0, idex_bubble_o=1; stall_cnt_o=1. Repeat with idex_rt_i=0 -> no stall.
- Branch vs load-use: branch_taken_i=1 with lu=1 -> ifid_flush_o=0, stall taken. Next cycle with branch_taken_i=1 and lu=0 -> ifid_flush_o=1, flush_cnt_o=1.
- Memory wait: exmem_memreq_i=1, dmem_ack_i raised 3 cycles later -> dmem_req_o high for 4 cycles, freeze for 3, memwb_bubble_o=1 for 3, stall_cnt_o=3, state returns to RUN.
- Same-cycle ack: exmem_memreq_i=1 with dmem_ack_i=1 -> dmem_req_o=1, no freeze, stall_cnt_o unchanged.
- Reset mid-wait: rst_i=0 during MEM_WAIT -> next cycle state RUN and dmem_req_o=0 after release. Separately, preload stall_cnt_o to 0xFFFF_FFFE and stall 3 cycles -> stall_cnt_o saturates at 0xFFFF_FFFF.
